mod_updown_counter: RTL and testbench
=====================================

Name: mod_updown_counter

Overview:
Parametrised successor to the team's fixed 3-bit free-running counter. Counts up or down with a programmable modulus, synchronous load and clear, count enable, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. Used as a general event, timer and index counter wherever a bare fixed-width counter was previously instantiated.

Parameters:
- WIDTH, 3: count register width in bits; legal range is 1..32.
- MAX_VAL, 2**WIDTH-1: modulus top, so the count range is 0..MAX_VAL. It must satisfy 1 <= MAX_VAL <= 2**WIDTH-1 (elaboration error otherwise).
- PRESCALE, 4: enable divider ratio, >= 1. Used only when COUNTER_PRESCALE_EN is defined.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- en  in  1  count enable.
- up_dn  in  1  direction: 1 = up, 0 = down.
- sat  in  1  mode: 1 = saturate, 0 = wrap.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered.
- ovf  out  1  sticky overflow/underflow flag, registered.

Behaviour:
- Reset: rst=1 immediately forces count=0, tc=0, ovf=0 and prescaler=0, independent of clk.
- Update priority on each rising edge: rst > clr > load > step > hold.
- clr:
  - count <= 0, ovf <= 0, tc <= 0.
  - The prescaler is also cleared.
- load:
  - count <= min(load_val, MAX_VAL); a load_val above MAX_VAL is clamped to MAX_VAL.
  - tc <= 0; ovf is unchanged; the prescaler is cleared.
- step (en=1 and the prescaler allows it, see Optional Feature):
  - Up, count < MAX_VAL: count+1.
  - Up, count == MAX_VAL: wrap mode gives 0; saturate mode holds MAX_VAL.
  - Down, count > 0: count-1.
  - Down, count == 0: wrap mode gives MAX_VAL; saturate mode holds 0.
  - Any boundary step (either mode): tc <= 1 for exactly one cycle, and ovf <= 1 (sticky).
- tc is 0 on every cycle without a boundary step. If en stays high at a saturated boundary, tc pulses on every step attempt.
- Latency: count, tc and ovf all update on the same edge that samples the controls. There are no combinational paths from inputs to outputs.
- up_dn and sat may change on any cycle and take effect on the next step.
- en=0 with no clr or load: all state holds and tc=0.
- Count arithmetic uses WIDTH+1 bits internally, so count never takes a value above MAX_VAL, even when MAX_VAL = 2**WIDTH-1.
- rst asserted mid-count: immediate return to the reset values. After deassertion, counting resumes from 0 on the first enabled edge.

Optional Feature:
- Macro: COUNTER_PRESCALE_EN.
- Defined:
  - An internal prescaler counter (0..PRESCALE-1) increments on each cycle with en=1.
  - A step occurs only on the cycle where the prescaler equals PRESCALE-1; the prescaler then wraps to 0.
  - The prescaler is reset by rst, clr and load. With PRESCALE=1 the behaviour is identical to the undefined case.
- Undefined: every en=1 cycle is a step. PRESCALE is ignored and no prescaler logic is generated.

Decomposition:
- Package counter_pkg holds:
  - the mode encoding constants MODE_WRAP=0 and MODE_SAT=1;
  - the direction constants DIR_DOWN=0 and DIR_UP=1;
  - a function clamp_load(val, max) used by both RTL and bench.
- One sub-module, en_prescaler: parameter PRESCALE; ports clk, rst, clr, en, tick. It is instantiated only under COUNTER_PRESCALE_EN.

Test Plan:
- Wrap up (WIDTH=3, MAX_VAL=5, sat=0, up_dn=1, en=1, macro off): count runs 0,1,2,3,4,5,0. tc=1 only on the edge 5->0, and ovf=1 from then on.
- Saturate down (sat=0 then 1): load 2, up_dn=0, en=1 gives count 2,1,0,0,0. tc pulses on each held-at-0 step and ovf=1. Then clr gives count=0, ovf=0.
- Priority/clamp (MAX_VAL=5): assert load=1 with load_val=7 → count=5. On the same cycle as clr=1, load=1, en=1 → count=0.
- Async reset (clk=0): assert rst=1 at count=3, mid-cycle, between edges → count=0, tc=0, ovf=0 before the next edge. Release rst and run 10 cycles → count follows 1,2,... from 0.
- Direction flip (MAX_VAL=7, sat=0): up from 6 → 7. Set up_dn=0 → 6,5. Down to 0 then one more step → 7, with tc=1.
- Prescale (COUNTER_PRESCALE_EN defined, PRESCALE=4, en=1): count increments once every 4 clocks (0 at clk 0-3, 1 at clk 4). A load mid-interval restarts the 4-cycle interval.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings and the load-clamp helper for mod_updown_counter and its bench.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  // Loads above the modulus top land on the top value instead of aliasing.
  function automatic int unsigned clamp_load(input int unsigned val, input int unsigned max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/en_prescaler.sv
// Divides the count enable by PRESCALE; tick is high on the en cycle that completes an interval.
module en_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    tick  = en && (pre_q == LAST);
    pre_d = pre_q;
    if (clr)       pre_d = '0;
    else if (tick) pre_d = '0;
    else if (en)   pre_d = pre_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down modulus counter with load, clear, wrap/saturate, tc pulse and sticky ovf.
// Define COUNTER_PRESCALE_EN to divide the enable by PRESCALE through en_prescaler.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 3,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int              PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("mod_updown_counter: WIDTH must be 1..32");
    end
    if (MAX_VAL < 1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
      $error("mod_updown_counter: MAX_VAL must be 1..2**WIDTH-1");
    end
    if (PRESCALE < 1) begin : g_bad_pre
      $error("mod_updown_counter: PRESCALE must be >= 1");
    end
  endgenerate

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);

  logic             pre_tick;
  logic             step;
  logic [WIDTH:0]   cnt_ext, up_ext, dn_ext;
  logic             at_top, at_bot;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

`ifdef COUNTER_PRESCALE_EN
  en_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr | load),
    .en   (en),
    .tick (pre_tick)
  );
`else
  assign pre_tick = 1'b1;
`endif

  assign step = en & pre_tick;

  // One extra bit so +1 past an all-ones MAX_VAL and -1 below zero are both visible.
  always_comb begin
    cnt_ext = {1'b0, count_q};
    up_ext  = cnt_ext + 1'b1;
    dn_ext  = cnt_ext - 1'b1;
    at_top  = (up_ext > MAX_EXT);
    at_bot  = dn_ext[WIDTH];
  end

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = WIDTH'(clamp_load(32'(load_val), 32'(MAX_VAL)));
    end else if (step) begin
      if (up_dn == DIR_UP) begin
        if (at_top) begin
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
          count_d = (sat == MODE_SAT) ? count_q : '0;
        end else begin
          count_d = up_ext[WIDTH-1:0];
        end
      end else begin
        if (at_bot) begin
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
          count_d = (sat == MODE_SAT) ? count_q : MAX_EXT[WIDTH-1:0];
        end else begin
          count_d = dn_ext[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench: MAX_VAL=5 and MAX_VAL=7 counters share stimulus; a PRESCALE=4 copy runs when enabled.
module tb_mod_updown_counter;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst, clr, load, en, up_dn, sat;
  logic [2:0] load_val;
  logic [2:0] c5, c7, cps;
  logic       tc5, tc7, tcps, ovf5, ovf7, ovfps;
  int         n_chk = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(3), .MAX_VAL(5), .PRESCALE(1)) u_dut5 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up_dn(up_dn), .sat(sat), .count(c5), .tc(tc5), .ovf(ovf5));

  mod_updown_counter #(.WIDTH(3), .PRESCALE(1)) u_dut7 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up_dn(up_dn), .sat(sat), .count(c7), .tc(tc7), .ovf(ovf7));

  mod_updown_counter #(.WIDTH(3), .MAX_VAL(7), .PRESCALE(4)) u_dutps (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up_dn(up_dn), .sat(sat), .count(cps), .tc(tcps), .ovf(ovfps));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk5(input string tag, input int ec, input int etc, input int eovf);
    chk({tag, ".count"}, 32'(c5), 32'(ec));
    chk({tag, ".tc"}, 32'(tc5), 32'(etc));
    chk({tag, ".ovf"}, 32'(ovf5), 32'(eovf));
  endtask

  task automatic chk7(input string tag, input int ec, input int etc, input int eovf);
    chk({tag, ".count"}, 32'(c7), 32'(ec));
    chk({tag, ".tc"}, 32'(tc7), 32'(etc));
    chk({tag, ".ovf"}, 32'(ovf7), 32'(eovf));
  endtask

  initial begin
    int wrap5 [6]    = '{1, 2, 3, 4, 5, 0};
    int satdn_c [5]  = '{1, 0, 0, 0, 0};
    int satdn_tc [5] = '{0, 0, 1, 1, 1};
    int dir_c [8]    = '{6, 5, 4, 3, 2, 1, 0, 7};

    rst = 1'b1; clr = 1'b0; load = 1'b0; load_val = 3'd0;
    en = 1'b0; up_dn = DIR_UP; sat = MODE_WRAP;
    #12;
    chk5("reset5", 0, 0, 0);
    chk7("reset7", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // wrap up through MAX_VAL=5
    en = 1'b1; up_dn = DIR_UP; sat = MODE_WRAP;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk5($sformatf("wrap_up[%0d]", i), wrap5[i], (i == 5) ? 1 : 0, (i == 5) ? 1 : 0);
    end
    en = 1'b0;
    tick();
    chk5("hold_en0", 0, 0, 1);

    // saturate down: clear, load 2, step down into 0 and stay there
    clr = 1'b1;
    tick();
    chk5("clr_a", 0, 0, 0);
    clr = 1'b0; load = 1'b1; load_val = 3'd2; up_dn = DIR_DOWN; sat = MODE_SAT;
    tick();
    chk5("load2", 2, 0, 0);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk5($sformatf("sat_dn[%0d]", i), satdn_c[i], satdn_tc[i], (i >= 2) ? 1 : 0);
    end
    en = 1'b0;
    tick();
    chk5("sat_dn_idle", 0, 0, 1);
    clr = 1'b1;
    tick();
    chk5("clr_b", 0, 0, 0);
    clr = 1'b0;

    // priority and clamp
    load = 1'b1; load_val = 3'd7;
    tick();
    chk("clamp5", 32'(c5), clamp_load(7, 5));
    chk("clamp5_lit", 32'(c5), 32'd5);
    chk("load7", 32'(c7), 32'd7);
    clr = 1'b1; en = 1'b1;
    tick();
    chk5("clr_over_load", 0, 0, 0);
    chk("clr_over_load7", 32'(c7), 32'd0);
    clr = 1'b0; load = 1'b0; en = 1'b0;

    // saturate up at top keeps pulsing tc
    load = 1'b1; load_val = 3'd5;
    tick();
    load = 1'b0; en = 1'b1; up_dn = DIR_UP; sat = MODE_SAT;
    tick();
    chk5("sat_up_a", 5, 1, 1);
    tick();
    chk5("sat_up_b", 5, 1, 1);

    // async reset with ovf set and count=3
    en = 1'b0; load = 1'b1; load_val = 3'd3;
    tick();
    load = 1'b0;
    chk5("pre_rst", 3, 0, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk5("async_rst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; up_dn = DIR_UP; sat = MODE_WRAP;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("post_rst[%0d]", i), 32'(c5), 32'(i % 6));
    end

    // direction flip on MAX_VAL=7
    en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0; load = 1'b1; load_val = 3'd6;
    tick();
    load = 1'b0; en = 1'b1; up_dn = DIR_UP; sat = MODE_WRAP;
    tick();
    chk7("dir_up", 7, 0, 0);
    up_dn = DIR_DOWN;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk7($sformatf("dir_dn[%0d]", i), dir_c[i], (i == 7) ? 1 : 0, (i == 7) ? 1 : 0);
    end

`ifdef COUNTER_PRESCALE_EN
    en = 1'b0; clr = 1'b1; up_dn = DIR_UP; sat = MODE_WRAP;
    tick();
    clr = 1'b0; en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("ps_run[%0d]", i), 32'(cps), (i == 4) ? 32'd1 : 32'd0);
    end
    tick();
    tick();
    chk("ps_mid", 32'(cps), 32'd1);
    load = 1'b1; load_val = 3'd2;
    tick();
    load = 1'b0;
    chk("ps_load", 32'(cps), 32'd2);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("ps_reload[%0d]", i), 32'(cps), (i == 4) ? 32'd3 : 32'd2);
    end
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
